// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter feeding a single registered output slot.
// Fixed-priority or round-robin grant, with an optional force onto one
// channel. The output register accepts a new word whenever it is empty or
// being drained in the same cycle, so back-to-back transfers have no bubble.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic               force_en,
    input  logic [SELW-1:0]    force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_sel
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q,  out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  last_q,     last_d;

    logic [N-1:0]     eligible;
    logic [SELW-1:0]  grant;
    logic             grant_any;
    logic             load_en;
    logic             xfer_in;

    // The output slot can take a word when empty or when it drains this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign xfer_in = grant_any && load_en && !reset;

    // Eligible channels; a force_sel that names no channel leaves none eligible.
    always_comb begin
        eligible = in_valid;
        if (force_en) begin
            for (int i = 0; i < N; i++) begin
                eligible[i] = in_valid[i] && (force_sel == SELW'(i));
            end
        end
    end

    // Grant search; loops run from lowest to highest priority so the last hit wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        if (mode) begin
            // Offset 1 from last is highest priority, offset N (last itself) lowest.
            for (int k = N; k >= 1; k--) begin
                idx = int'(last_q) + k;
                if (idx >= N) idx = idx - N;
                if (eligible[SELW'(idx)]) begin
                    grant     = SELW'(idx);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant     = SELW'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

    // One-hot accept to the granted channel only when the word is actually taken.
    always_comb begin
        in_ready = '0;
        if (xfer_in) in_ready[grant] = 1'b1;
    end

    // Output slot and round-robin pointer next state.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer_in) begin
            out_data_d  = in_data[grant*WIDTH +: WIDTH];
            out_sel_d   = grant;
            out_valid_d = 1'b1;
            last_d      = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held word and points RR at channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the data width per channel.
REQ-002 The module SHALL have parameter N, default 4, meaning the input channel count (N >= 2).
REQ-003 The module SHALL have parameter SELW, default 2, meaning the select width (SELW = clog2(N)).
REQ-004 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port in_data, input, N*WIDTH, SHALL carry channel i in bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, N, SHALL carry a per-channel valid.
REQ-008 Port in_ready, output, N, SHALL be a per-channel accept, one-hot or zero.
REQ-009 Port mode, input, 1, SHALL select arbitration: 0 = fixed priority, 1 = round robin.
REQ-010 Port force_en, input, 1, when 1 SHALL restrict eligibility to channel force_sel.
REQ-011 Port force_sel, input, SELW, SHALL name the forced channel.
REQ-012 Port out_data, output, WIDTH, SHALL be the registered selected data.
REQ-013 Port out_valid, output, 1, SHALL mark out_data as valid.
REQ-014 Port out_ready, input, 1, SHALL be the downstream accept.
REQ-015 Port out_sel, output, SELW, SHALL be the registered index of the channel that supplied out_data.

Function
REQ-016 Transfers: a transfer on channel i SHALL occur when in_valid[i] && in_ready[i] at a rising edge; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 Load condition: load_en SHALL equal !out_valid || out_ready; in_ready SHALL be all-zero when load_en = 0 or reset = 1.
REQ-018 Eligible set: eligible = in_valid, masked to bit force_sel when force_en = 1.
REQ-019 Fixed priority (mode 0): the grant SHALL be the lowest-index eligible channel.
REQ-020 Round robin (mode 1): the search SHALL start at (last+1) mod N, wrapping from N-1 to 0, where last is the index of the most recent accepted transfer.
REQ-021 Forced selection: when force_en = 1, channel force_sel SHALL be granted iff it is valid, regardless of mode; force_sel >= N SHALL grant nothing.
REQ-022 Combinational grant: in_ready[grant] = load_en when any channel is eligible; in_ready SHALL depend combinationally on in_valid, mode, force_* and out_ready.
REQ-023 Output load: on an input transfer, out_data <= in_data[grant], out_sel <= grant, out_valid <= 1 at the same edge, giving 1-cycle latency.
REQ-024 Output drain: on an output transfer with no input transfer, out_valid <= 0, and out_data/out_sel SHALL hold their values.
REQ-025 Simultaneous transfers: on a simultaneous output and input transfer, the new word SHALL replace the old one with no bubble, sustaining 1 word/cycle.
REQ-026 Stall: while out_valid && !out_ready, out_data, out_sel and out_valid SHALL be stable, and no input SHALL be accepted.
REQ-027 Pointer update: last SHALL update only on an input transfer, in both modes and when forced; it SHALL be unchanged otherwise.
REQ-028 Idle: no eligible channel SHALL mean no grant, no state change except the drain, and in_ready = 0.
REQ-029 Mode or force change: these SHALL take effect on the next grant evaluation, and the held output word SHALL be unaffected.

Reset
REQ-030 While reset is high at an edge: out_valid <= 0, out_data <= 0, out_sel <= 0, last <= N-1 (so channel 0 is first in round robin).
REQ-031 Reset SHALL override any in-flight transfer in the same cycle, and the held word SHALL be discarded.

Verification
REQ-032 Fixed priority: mode=0, in_valid=4'b1110, d1=32'habcd1234, d2=32'h11112222, out_ready=1 -> next cycle out_data=32'habcd1234, out_sel=1, in_ready=4'b0010.
REQ-033 Round robin: mode=1, in_valid=4'b1111 held, out_ready=1, after reset -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 throughout.
REQ-034 Backpressure: word loaded, out_ready=0 for 3 cycles -> out_data and out_sel stable, in_ready=0; out_ready=1 -> next word loads the same cycle, no bubble.
REQ-035 Force: force_en=1, force_sel=3, in_valid=4'b1001, d3=32'h0 -> out_sel=3, out_data=0; in_valid=4'b0001 with force still on -> out_valid drops after drain, in_ready=0.
REQ-036 Reset mid-stream: reset=1 while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_sel=0; round robin restarts at channel 0.
REQ-037 Wrap: N=3, SELW=2, mode=1, last=2, in_valid=3'b101 -> grant 0, then grant 2, then grant 0.
